fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/definitions.sv | 21 ++
 rtl/fetch_pc_gen.sv | 36 +++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared definitions for the fetch stage.
//   kNOP          : instruction word presented while the stage has nothing valid
//   fd_s          : payload handed to the fetch/decode pipeline register
//   fetch_state_e : fetch control states
package definitions;

   localparam logic [31:0] kNOP = 32'h0000_0013;  // addi x0, x0, 0

   typedef struct packed {
      logic [31:0] instruction_fd;
      logic [31:0] PC_r_fd;
   } fd_s;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,  // no request outstanding, issue one at pc
      WAIT  = 2'd1,  // one request outstanding for pc
      HOLD  = 2'd2,  // word for pc parked in the hold buffer during a stall
      DRAIN = 2'd3   // one request outstanding whose data must be thrown away
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch program counter: pc register, +4 incrementer and redirect mux.
//   clk, reset          : clock, synchronous active-high reset (pc <= RESET_PC)
//   advance_i           : step pc to pc+4
//   redirect_i          : load redirect target (wins over advance_i)
//   redirect_pc_i       : redirect target, low two bits are dropped
//   pc_o                : current pc
//   pc_seq_o            : pc+4 (modulo 2^32)
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_seq_o
);

   logic [31:0] pc_q, pc_d;

   assign pc_seq_o = pc_q + 32'd4;  // natural wrap at 2^32
   assign pc_o     = pc_q;

   always_comb begin
      pc_d = pc_q;
      if (redirect_i)     pc_d = {redirect_pc_i[31:2], 2'b00};
      else if (advance_i) pc_d = pc_seq_o;
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with at most one instruction-memory read in flight.
//   clk, reset         : clock, synchronous active-high reset
//   stall_i            : FD register holds this cycle
//   redirect_i/_pc_i   : taken branch/jump and its target
//   imem_req_o/addr_o  : single-cycle read request, word-aligned address
//   imem_valid_i/rdata_i : read response (>=1 cycle after its request)
//   fd_s_o, bubble_o   : payload and bubble flag for the FD register
// Optional build macro FETCH_PERF_EN adds saturating counters
//   perf_fetch_cnt_o (delivery cycles) and perf_bubble_cnt_o (bubble cycles,
//   reset cycles excluded).
module fetch_stage
   import definitions::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   output fd_s         fd_s_o,
   output logic        bubble_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt_o,
   output logic [31:0] perf_bubble_cnt_o
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  hold_q, hold_d;
   logic         drop_q, drop_d;   // a pre-reset response is still in flight
   logic [31:0]  pc, pc_seq, instr;
   logic         advance, pend;

   fetch_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
      .clk           (clk),
      .reset         (reset),
      .advance_i     (advance),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .pc_o          (pc),
      .pc_seq_o      (pc_seq)
   );

   // Request still in flight after this cycle if reset lands now.
   assign pend = ((state_q == WAIT) || (state_q == DRAIN) || drop_q) && !imem_valid_i;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      drop_d      = drop_q;
      imem_req_o  = 1'b0;
      imem_addr_o = pc;
      bubble_o    = 1'b1;
      instr       = kNOP;
      advance     = 1'b0;
      case (state_q)
         BOOT: begin
            // Nothing of ours is outstanding, so any response here is stale.
            if (imem_valid_i) drop_d = 1'b0;
            if (!redirect_i && (!drop_q || imem_valid_i)) begin
               imem_req_o = 1'b1;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               state_d = imem_valid_i ? BOOT : DRAIN;
            end else if (imem_valid_i) begin
               if (stall_i) begin
                  hold_d  = imem_rdata_i;
                  state_d = HOLD;
               end else begin
                  bubble_o    = 1'b0;
                  instr       = imem_rdata_i;
                  imem_req_o  = 1'b1;
                  imem_addr_o = pc_seq;
                  advance     = 1'b1;
               end
            end
         end
         HOLD: begin
            if (redirect_i) begin
               state_d = BOOT;
            end else if (!stall_i) begin
               bubble_o    = 1'b0;
               instr       = hold_q;
               imem_req_o  = 1'b1;
               imem_addr_o = pc_seq;
               advance     = 1'b1;
               state_d     = WAIT;
            end
         end
         DRAIN: begin
            // Wrong-path data arrives: discard it and fetch at the new pc,
            // unless yet another redirect is moving pc this very cycle.
            if (imem_valid_i) begin
               if (redirect_i) begin
                  state_d = BOOT;
               end else begin
                  imem_req_o = 1'b1;
                  state_d    = WAIT;
               end
            end
         end
         default: state_d = BOOT;
      endcase
      if (reset) begin
         imem_req_o = 1'b0;
         bubble_o   = 1'b1;
         instr      = kNOP;
      end
   end

   assign fd_s_o.instruction_fd = instr;
   assign fd_s_o.PC_r_fd        = reset ? RESET_PC : pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
         hold_q  <= '0;
         drop_q  <= pend;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         drop_q  <= drop_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (!bubble_o) begin
         if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end else begin
         if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt_o  = fetch_cnt_q;
   assign perf_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural instruction memory with programmable
// latency, cycle tables of expected control outputs, and a scoreboard of
// expected deliveries popped whenever the stage reports bubble_o=0.
module tb_fetch_stage;
   import definitions::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0, reset = 1'b1, stall_i = 1'b0, redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        imem_req_o, bubble_o;
   logic [31:0] imem_addr_o;
   logic        imem_valid_i = 1'b0;
   logic [31:0] imem_rdata_i = 32'hDEAD_BEEF;
   fd_s         fd_s_o;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt_o, perf_bubble_cnt_o;
`endif

   int errors = 0, checks = 0;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_valid_i  (imem_valid_i),
      .imem_rdata_i  (imem_rdata_i),
      .fd_s_o        (fd_s_o),
      .bubble_o      (bubble_o)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt_o  (perf_fetch_cnt_o),
      .perf_bubble_cnt_o (perf_bubble_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h0000_010C) ? 32'h00A0_0093 : (a ^ 32'hC0DE_0000);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // ---- instruction memory model ----
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int    cyc = 0;
   int    lat = 1;
   bit    presented = 1'b0;

   always @(negedge clk)
      if (imem_req_o === 1'b1) mq.push_back('{imem_addr_o, cyc + lat});

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (presented) begin
         void'(mq.pop_front());
         presented = 1'b0;
      end
      imem_valid_i = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         imem_valid_i = 1'b1;
         imem_rdata_i = mem(mq[0].addr);
         presented    = 1'b1;
      end
   end

   // ---- delivery scoreboard ----
   fd_s sb[$];
   fd_s sb_exp;

   always @(negedge clk) begin
      if (reset === 1'b0 && bubble_o === 1'b0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deliver_unexpected: got instr=%h pc=%h, required no delivery",
                     fd_s_o.instruction_fd, fd_s_o.PC_r_fd);
         end else begin
            sb_exp = sb.pop_front();
            chk("deliver_instr", fd_s_o.instruction_fd, sb_exp.instruction_fd);
            chk("deliver_pc", fd_s_o.PC_r_fd, sb_exp.PC_r_fd);
         end
      end
   end

   // ---- one cycle: drive inputs, check outputs at the falling edge ----
   typedef struct {
      logic        st, rd;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        bub;
      logic [31:0] pc;
   } vec_t;

   task automatic run_row(input vec_t v, input string tag);
      stall_i = v.st; redirect_i = v.rd; redirect_pc_i = v.rpc;
      if (!v.bub && !reset) sb.push_back('{mem(v.pc), v.pc});
      @(negedge clk);
      chk({tag, "_req"}, 32'(imem_req_o), 32'(v.req));
      if (v.req) chk({tag, "_addr"}, imem_addr_o, v.addr);
      chk({tag, "_bubble"}, 32'(bubble_o), 32'(v.bub));
      chk({tag, "_pc"}, fd_s_o.PC_r_fd, v.pc);
      if (v.bub) chk({tag, "_nop"}, fd_s_o.instruction_fd, kNOP);
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_bubble", 32'(bubble_o), 32'd1);
      chk("rst_pc", fd_s_o.PC_r_fd, RST_PC);
      chk("rst_instr", fd_s_o.instruction_fd, kNOP);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic req, input logic [31:0] addr,
                               input logic bub, input logic [31:0] pc);
      vec_t v;
      v.st = st; v.rd = rd; v.rpc = rpc; v.req = req; v.addr = addr; v.bub = bub; v.pc = pc;
      return v;
   endfunction

   vec_t tbl[18];
   vec_t seq[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1-cycle memory: streaming, 3-cycle stall on 0x00A00093, redirects
      tbl[0]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b1, 32'h100);
      tbl[1]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h104,       1'b0, 32'h100);
      tbl[2]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h108,       1'b0, 32'h104);
      tbl[3]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h10C,       1'b0, 32'h108);
      tbl[4]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h10C);
      tbl[5]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h10C);
      tbl[6]  = mk(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h10C);
      tbl[7]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h110,       1'b0, 32'h10C);
      tbl[8]  = mk(1'b1, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1, 32'h110);
      tbl[9]  = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h200,       1'b1, 32'h200);
      tbl[10] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h204,       1'b0, 32'h200);
      tbl[11] = mk(1'b0, 1'b1, 32'h303,       1'b0, 32'h0,         1'b1, 32'h204);
      tbl[12] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h300,       1'b1, 32'h300);
      tbl[13] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h304,       1'b0, 32'h300);
      tbl[14] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 32'h304);
      tbl[15] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
      tbl[16] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'hFFFF_FFFC);
      tbl[17] = mk(1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0);

      lat = 1;
      do_reset(4);
      for (int i = 0; i < 18; i++) run_row(tbl[i], $sformatf("tbl%0d", i));
      chk("tbl_sb_drained", 32'(sb.size()), 32'd0);

      // redirect while a 3-cycle request is outstanding: DRAIN path
      lat = 3;
      do_reset(5);
      run_row(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h100), "drn0");
      run_row(mk(1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 32'h100), "drn1");
      run_row(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200), "drn2");
      run_row(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b1, 32'h200), "drn3");
      run_row(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200), "drn4");
      run_row(mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h200), "drn5");
      run_row(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h200), "drn6");
      chk("drn_sb_drained", 32'(sb.size()), 32'd0);

      // reset mid-request (with redirect/stall also high): stale data dropped
      lat = 3;
      do_reset(5);
      run_row(mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h100), "rmr0");
      reset = 1'b1;
      run_row(mk(1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   1'b1, 32'h100), "rmr1");
      reset = 1'b0;
      seq.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h100));
      seq.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h100));
      seq.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h100));
      seq.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h100));
      seq.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h100));
      for (int i = 0; i < seq.size(); i++) run_row(seq[i], $sformatf("rmr%0d", i + 2));
      chk("rmr_sb_drained", 32'(sb.size()), 32'd0);

`ifdef FETCH_PERF_EN
      // 10 deliveries, 4 bubble cycles (boot + 3 stalled)
      lat = 1;
      do_reset(5);
      run_row(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h100), "prf0");
      for (int k = 1; k <= 10; k++)
         run_row(mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h100 + 32'(4 * k), 1'b0,
                    32'h100 + 32'(4 * (k - 1))), $sformatf("prf%0d", k));
      for (int k = 11; k <= 13; k++)
         run_row(mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h128), $sformatf("prf%0d", k));
      stall_i = 1'b1;
      @(negedge clk);
      chk("perf_fetch_cnt", perf_fetch_cnt_o, 32'd10);
      chk("perf_bubble_cnt", perf_bubble_cnt_o, 32'd4);
      @(posedge clk); #1;
      chk("prf_sb_drained", 32'(sb.size()), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
